// File: rtl/mem_eeprom_pkg.sv
// Shared geometry and address-slicing helpers for the 64Kx1 EEPROM backing RAM.
// The array splits into BANKS equal block-RAM banks selected by the top address bits.
package mem_eeprom_pkg;

    localparam int unsigned AW      = 16;
    localparam int unsigned BANKS   = 4;
    localparam int unsigned BANK_SW = $clog2(BANKS);
    localparam int unsigned BANK_AW = AW - BANK_SW;

    typedef logic [AW-1:0]      addr_t;
    typedef logic [BANK_SW-1:0] bank_sel_t;
    typedef logic [BANK_AW-1:0] bank_off_t;

    function automatic bank_sel_t bank_sel(input addr_t i_ad);
        return i_ad[AW-1 -: BANK_SW];
    endfunction

    function automatic bank_off_t bank_off(input addr_t i_ad);
        return i_ad[BANK_AW-1:0];
    endfunction

endpackage

// File: rtl/eeprom_bank_ram.sv
// One 2**AW x 1 read-before-write block RAM bank with clock enable and write enable.
// Reset clears only the read register; stored bits are never touched by reset.
module eeprom_bank_ram #(
    parameter int unsigned AW = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_we,
    input  logic [AW-1:0] i_ad,
    input  logic          i_din,
    output logic          o_dout
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic r_mem [DEPTH];
    logic r_q;

    // The write commits even when reset is asserted in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_ce && i_we) begin
            r_mem[i_ad] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= 1'b0;
        end else if (i_ce) begin
            r_q <= r_mem[i_ad];
        end
    end

    assign o_dout = r_q;

endmodule

// File: rtl/mem_eeprom_64kx1.sv
// 65536 x 1 single-port synchronous RAM built from BANKS block-RAM banks.
// Define MEM_EEPROM_OUTREG_EN to add an oce-gated output register (latency 2).
module mem_eeprom_64kx1
    import mem_eeprom_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] ad,
    input  logic          wre,
    input  logic          oce,
    input  logic          din,
    output logic          dout
);

    logic [BANKS-1:0] w_bank_ce;
    logic [BANKS-1:0] w_bank_q;
    bank_off_t        w_off;
    bank_sel_t        r_bank_sel;
    logic             w_rd;

    assign w_off = bank_off(ad);

    // Only the addressed bank sees ce, so writes and reads stay local to it.
    always_comb begin
        w_bank_ce = '0;
        if (ce) begin
            w_bank_ce[bank_sel(ad)] = 1'b1;
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        eeprom_bank_ram #(
            .AW (BANK_AW)
        ) u_bank (
            .i_clk   (clk),
            .i_reset (reset),
            .i_ce    (w_bank_ce[g]),
            .i_we    (wre),
            .i_ad    (w_off),
            .i_din   (din),
            .o_dout  (w_bank_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank_sel <= '0;
        end else if (ce) begin
            r_bank_sel <= bank_sel(ad);
        end
    end

    assign w_rd = w_bank_q[r_bank_sel];

`ifdef MEM_EEPROM_OUTREG_EN
    logic r_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= 1'b0;
        end else if (oce) begin
            r_out <= w_rd;
        end
    end

    assign dout = r_out;
`else
    logic w_unused_oce;

    assign w_unused_oce = oce;
    assign dout         = w_rd;
`endif

endmodule

// File: tb/tb_mem_eeprom_64kx1.sv
// Self-checking bench for mem_eeprom_64kx1: array-level model plus directed literal checks.
// Honours MEM_EEPROM_OUTREG_EN the same way as the design.
module tb_mem_eeprom_64kx1;

`ifdef MEM_EEPROM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        ce;
    logic [15:0] ad;
    logic        wre;
    logic        oce;
    logic        din;
    logic        dout;

    int vectors;
    int miscompares;

    // Model: stored bit plus "known" flag per address; read stage and output stage.
    bit mv [65536];
    bit mk [65536];
    bit rd_v, rd_k, out_v, out_k, nv, nk, exp_v, exp_k;

    mem_eeprom_64kx1 u_dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .ad    (ad),
        .wre   (wre),
        .oce   (oce),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        nv = rd_v;
        nk = rd_k;
        if (reset) begin
            nv = 1'b0;
            nk = 1'b1;
        end else if (ce) begin
            nv = mv[ad];
            nk = mk[ad];
        end
        if (ce && wre) begin
            mv[ad] = din;
            mk[ad] = 1'b1;
        end
        if (reset) begin
            out_v = 1'b0;
            out_k = 1'b1;
        end else if (oce) begin
            out_v = rd_v;
            out_k = rd_k;
        end
        rd_v = nv;
        rd_k = nk;
    end

`ifdef MEM_EEPROM_OUTREG_EN
    assign exp_v = out_v;
    assign exp_k = out_k;
`else
    assign exp_v = rd_v;
    assign exp_k = rd_k;
`endif

    always @(negedge clk) begin
        if (exp_k) begin
            vectors++;
            if (dout !== exp_v) begin
                miscompares++;
                $display("FAIL model t=%0t ad=%h: dout=%b expected=%b", $time, ad, dout, exp_v);
            end
        end
    end

    task automatic cyc(input logic r, input logic c, input logic w, input logic [15:0] a,
                       input logic d);
        reset = r;
        ce    = c;
        wre   = w;
        ad    = a;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'hxxxx, 1'b0);
    endtask

    task automatic check_lit(input string name, input logic exp);
        vectors++;
        if (dout !== exp) begin
            miscompares++;
            $display("FAIL %s: dout=%b expected=%b", name, dout, exp);
        end
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic exp);
        cyc(1'b0, 1'b1, 1'b0, a, 1'b0);
        idle(LAT - 1);
        check_lit(name, exp);
    endtask

    logic [15:0] t2_addr [5];
    logic        t2_data [5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        oce   = 1'b1;
        reset = 1'b1;
        ce    = 1'b0;
        wre   = 1'b0;
        din   = 1'b0;
        ad    = 16'h0000;

        // 1. reset, then ce=0 holds zero
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_lit("reset_zero", 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_lit("ce0_after_reset", 1'b0);
        end

        // 2. directed writes across bank edges
        t2_addr = '{16'h0000, 16'h3FFF, 16'h4000, 16'hFFFF, 16'h0001};
        t2_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, t2_addr[i], t2_data[i]);
        for (int i = 0; i < 5; i++) read_check("t2_readback", t2_addr[i], t2_data[i]);

        // 3. fill with ones, clear one bit, sweep a subset
        for (int i = 0; i < 65536; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i), 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            if ((i % 16384) < 64 || (i % 16384) >= 16320 || (i >= 'h1200 && i < 'h1300) ||
                (i % 61) == 0) begin
                cyc(1'b0, 1'b1, 1'b0, 16'(i), 1'b0);
            end
        end
        idle(LAT);
        read_check("t3_cleared_bit", 16'h1234, 1'b0);
        read_check("t3_neighbour", 16'h1235, 1'b1);
        read_check("t3_other_bank", 16'h5234, 1'b1);

        // 4. read-before-write
        cyc(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
        idle(LAT - 1);
        check_lit("t4_old_bit", 1'b0);
        read_check("t4_new_bit", 16'h0040, 1'b1);

        // 5. write with ce=0 is ignored, dout holds
        read_check("t5_before", 16'hFFFF, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        check_lit("t5_hold", 1'b1);
        read_check("t5_after", 16'hFFFF, 1'b1);

        // 6. pattern in block 5, reset pulse with a concurrent write
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b1, 16'h0140 + 16'(i), ~i[0]);
        read_check("t6_pre_reset", 16'h0140, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h0180, 1'b0);
        check_lit("t6_reset_zero", 1'b0);
        for (int i = 0; i < 64; i++) read_check("t6_pattern", 16'h0140 + 16'(i), ~i[0]);
        read_check("t6_write_during_reset", 16'h0180, 1'b0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
